// File: rtl/fetch_stage.sv
// fetch_stage - instruction fetch stage.
//
// Owns the PC, issues one word read at a time to instruction memory and
// parks each returned instruction, together with its PC, in a one-entry
// IF/ID buffer. Redirects replace the PC and flush the buffer. A halt stops
// fetching for good, until reset.
//
// Ports
//   clk, rst_n                        clock (rising edge), async active-low reset
//   imem_req_valid/ready, imem_addr   fetch request channel (word aligned)
//   imem_rsp_valid, imem_rsp_data     fetch response, one per accepted request
//   redirect_valid, redirect_pc       taken branch/jump target
//   halt                              ECALL/EBREAK seen by decode
//   out_valid/ready, out_instr/pc     IF/ID buffer toward decode
//   out_opcode                        out_instr[6:2], to the control unit
//   halted                            fetch has stopped
module fetch_stage #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            halt,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instr,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      out_opcode,
    output logic            halted
);

    typedef enum logic [1:0] {
        S_REQ    = 2'd0,
        S_WAIT   = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t          state, state_d;
    logic [XLEN-1:0] pc, pc_d;
    logic            drop, drop_d;         // outstanding response is stale
    logic            halt_pend, halt_pend_d; // halt seen while a request is in flight
    logic            armed;                // keeps the request line low during and just after reset
    logic            ov_d;
    logic [31:0]     oi_d;
    logic [XLEN-1:0] op_d;
    logic            accept, rsp;
    logic [XLEN-1:0] tgt;

    assign tgt = {redirect_pc[XLEN-1:2], 2'b00};

    // Only request when the buffer can take the result; halt withdraws the
    // request in the very cycle it is seen.
    assign imem_req_valid = armed && (state == S_REQ) && !halt && (!out_valid || out_ready);
    assign imem_addr      = {pc[XLEN-1:2], 2'b00};
    assign accept         = imem_req_valid && imem_req_ready;
    assign rsp            = (state == S_WAIT) && imem_rsp_valid;
    assign out_opcode     = out_instr[6:2];
    assign halted         = (state == S_HALTED);

    always_comb begin
        state_d     = state;
        pc_d        = pc;
        drop_d      = drop;
        halt_pend_d = halt_pend;
        ov_d        = out_valid && !out_ready;
        oi_d        = out_instr;
        op_d        = out_pc;
        case (state)
            S_REQ: begin
                if (halt) begin
                    // nothing in flight: stop right away, pc untouched
                    state_d = S_HALTED;
                    ov_d    = 1'b0;
                end else begin
                    if (accept)
                        state_d = S_WAIT;
                    if (redirect_valid) begin
                        pc_d = tgt;
                        ov_d = 1'b0;
                        // request to the old pc went out this cycle
                        if (accept)
                            drop_d = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (halt || halt_pend) begin
                    ov_d        = 1'b0;
                    halt_pend_d = 1'b1;
                    if (rsp) begin
                        state_d     = S_HALTED;
                        halt_pend_d = 1'b0;
                        drop_d      = 1'b0;
                    end
                end else if (redirect_valid) begin
                    pc_d = tgt;
                    ov_d = 1'b0;
                    if (rsp) begin
                        // response is consumed (and thrown away) right now
                        state_d = S_REQ;
                        drop_d  = 1'b0;
                    end else begin
                        drop_d = 1'b1;
                    end
                end else if (rsp) begin
                    state_d = S_REQ;
                    drop_d  = 1'b0;
                    if (!drop) begin
                        ov_d = 1'b1;
                        oi_d = imem_rsp_data;
                        op_d = pc;
                        pc_d = pc + XLEN'(4);
                    end
                end
            end
            S_HALTED: begin
                ov_d = 1'b0;
            end
            default: begin
                state_d = S_REQ;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_REQ;
            pc        <= RESET_PC;
            drop      <= 1'b0;
            halt_pend <= 1'b0;
            armed     <= 1'b0;
            out_valid <= 1'b0;
            out_instr <= '0;
            out_pc    <= '0;
        end else begin
            state     <= state_d;
            pc        <= pc_d;
            drop      <= drop_d;
            halt_pend <= halt_pend_d;
            armed     <= 1'b1;
            out_valid <= ov_d;
            out_instr <= oi_d;
            out_pc    <= op_d;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, hand sequences for the
// multi-cycle corners, and a randomized run scored against a transaction
// level model of the delivered (pc, instr) stream.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        out_valid, out_ready;
    logic [31:0] out_instr, out_pc;
    logic [4:0]  out_opcode;
    logic        halted;

    // second instance for the PC wrap case
    logic        b_rst_n, b_req_valid, b_rsp_valid, b_out_valid, b_halted;
    logic [31:0] b_addr, b_rsp_data, b_out_instr, b_out_pc;
    logic [4:0]  b_out_opcode;

    always #5 clk = ~clk;

    fetch_stage #(.XLEN(32), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
        .out_opcode(out_opcode), .halted(halted)
    );

    fetch_stage #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst_n(b_rst_n),
        .imem_req_valid(b_req_valid), .imem_req_ready(1'b1), .imem_addr(b_addr),
        .imem_rsp_valid(b_rsp_valid), .imem_rsp_data(b_rsp_data),
        .redirect_valid(1'b0), .redirect_pc(32'h0), .halt(1'b0),
        .out_valid(b_out_valid), .out_ready(1'b1), .out_instr(b_out_instr), .out_pc(b_out_pc),
        .out_opcode(b_out_opcode), .halted(b_halted)
    );

    typedef struct {
        logic [31:0] instr;
        logic [4:0]  opc;
        logic [31:0] pc;
    } vec_t;

    vec_t        tv [6];
    logic [31:0] mem [256];
    int          n_chk = 0, n_fail = 0;

    // memory model state
    int          cyc = 0, m_lat = 1, m_rsp_at = 0, rdy_pct = 100;
    logic        m_pend = 1'b0;
    logic [31:0] m_addr = '0;
    logic [31:0] acc_q [$];

    // per-cycle samples
    logic        s_rv, s_acc, s_rsp, s_ov, s_halted;
    logic [31:0] s_addr, s_pc, s_instr;
    logic [4:0]  s_opc;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // One clock cycle: memory drives at the falling edge, outputs sampled
    // just after, the DUT registers at the rising edge.
    task automatic tick();
        @(negedge clk);
        imem_rsp_valid = m_pend && (cyc == m_rsp_at);
        imem_rsp_data  = imem_rsp_valid ? mem[m_addr[9:2]] : 32'hDEAD_BEEF;
        imem_req_ready = (rdy_pct >= 100) || ($urandom_range(99) < 32'(rdy_pct));
        #1;
        s_rv = imem_req_valid; s_addr = imem_addr; s_acc = imem_req_valid && imem_req_ready;
        s_rsp = imem_rsp_valid; s_ov = out_valid; s_pc = out_pc; s_instr = out_instr;
        s_opc = out_opcode; s_halted = halted;
        if (s_acc) begin
            acc_q.push_back(s_addr);
            if (m_pend && !s_rsp) chk("one_outstanding", 32'(m_pend), 32'h0);
        end
        @(posedge clk);
        if (s_rsp) m_pend = 1'b0;
        if (s_acc) begin
            m_pend = 1'b1; m_addr = s_addr; m_rsp_at = cyc + m_lat;
        end
        cyc++;
        #1;
    endtask

    task automatic wait_acc(input string nm);
        int g = 0;
        do begin tick(); g++; end while (!s_acc && g < 40);
        if (!s_acc) chk(nm, 32'h0, 32'h1);
    endtask

    task automatic wait_ov(input string nm);
        int g = 0;
        do begin tick(); g++; end while (!s_ov && g < 40);
        if (!s_ov) chk(nm, 32'h0, 32'h1);
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, "_req_valid"}, 32'(imem_req_valid), 32'h0);
        chk({nm, "_out_valid"}, 32'(out_valid), 32'h0);
        chk({nm, "_halted"},    32'(halted), 32'h0);
        chk({nm, "_out_pc"},    out_pc, 32'h0);
        chk({nm, "_out_instr"}, out_instr, 32'h0);
        chk({nm, "_addr"},      imem_addr, 32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] held_pc, held_instr, exp_pc, p_pc, p_instr, p_addr, w_addr [2];
        logic        p_hold, p_rq;
        int          g, nw, delivered;

        for (int i = 0; i < 256; i++) mem[i] = (32'(i) * 32'h9E37_79B1) ^ 32'h0000_0013;
        tv[0] = '{32'h00B5_0533, 5'b01100, 32'h00};
        tv[1] = '{32'h0015_0513, 5'b00100, 32'h04};
        tv[2] = '{32'hFE05_1EE3, 5'b11000, 32'h08};
        tv[3] = '{32'h0080_006F, 5'b11011, 32'h0C};
        tv[4] = '{32'h0005_2583, 5'b00000, 32'h10};
        tv[5] = '{32'h0000_0073, 5'b11100, 32'h14};
        for (int i = 0; i < 6; i++) mem[i] = tv[i].instr;

        rst_n = 1'b0; b_rst_n = 1'b0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        redirect_valid = 1'b0; redirect_pc = '0; halt = 1'b0; out_ready = 1'b1;
        b_rsp_valid = 1'b0; b_rsp_data = '0;
        #1;
        chk_reset_outputs("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // ---- directed vector table: 1-cycle memory, always ready ----
        m_lat = 1; rdy_pct = 100; out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wait_ov("tbl_timeout");
            chk("tbl_out_pc", s_pc, tv[i].pc);
            chk("tbl_out_instr", s_instr, tv[i].instr);
            chk("tbl_out_opcode", 32'(s_opc), 32'(tv[i].opc));
        end
        chk("tbl_req_count", 32'(acc_q.size() >= 6), 32'h1);
        for (int i = 0; i < 6 && i < acc_q.size(); i++) chk("tbl_req_addr", acc_q[i], tv[i].pc);

        // ---- backpressure: buffer full blocks new requests ----
        out_ready = 1'b0;
        wait_ov("hold_timeout");
        held_pc = s_pc; held_instr = s_instr;
        repeat (6) begin
            tick();
            chk("hold_req_valid", 32'(s_rv), 32'h0);
            chk("hold_out_valid", 32'(s_ov), 32'h1);
            chk("hold_out_pc", s_pc, held_pc);
            chk("hold_out_instr", s_instr, held_instr);
        end
        m_lat = 3;
        out_ready = 1'b1;
        wait_acc("release_timeout");
        chk("release_addr", s_addr, held_pc + 32'h4);

        // ---- redirect while waiting on a response ----
        redirect_valid = 1'b1; redirect_pc = 32'h103;
        tick();
        redirect_valid = 1'b0;
        chk("rdw_rsp_not_yet", 32'(s_rsp), 32'h0);
        acc_q.delete();
        wait_ov("rdw_timeout");
        chk("rdw_first_out_pc", s_pc, 32'h100);
        chk("rdw_first_instr", s_instr, mem[8'h40]);
        chk("rdw_first_addr", (acc_q.size() > 0) ? acc_q[0] : 32'hX, 32'h100);

        // ---- redirect with a full, stalled buffer: flush ----
        out_ready = 1'b0;
        wait_ov("flush_timeout");
        acc_q.delete();
        redirect_valid = 1'b1; redirect_pc = 32'h202;
        tick();
        redirect_valid = 1'b0;
        chk("flush_ov_before", 32'(s_ov), 32'h1);
        tick();
        chk("flush_ov_after", 32'(s_ov), 32'h0);
        out_ready = 1'b1;
        g = 0;
        while (acc_q.size() == 0 && g < 40) begin tick(); g++; end
        chk("flush_next_addr", (acc_q.size() > 0) ? acc_q[0] : 32'hX, 32'h200);

        // ---- redirect in the same cycle as the response ----
        m_lat = 2;
        g = 0;
        while (!(m_pend && cyc == m_rsp_at) && g < 40) begin tick(); g++; end
        acc_q.delete();
        redirect_valid = 1'b1; redirect_pc = 32'h300;
        tick();
        redirect_valid = 1'b0;
        chk("rdr_rsp_seen", 32'(s_rsp), 32'h1);
        tick();
        chk("rdr_discarded", 32'(s_ov), 32'h0);
        wait_ov("rdr_timeout");
        chk("rdr_out_pc", s_pc, 32'h300);
        chk("rdr_first_addr", (acc_q.size() > 0) ? acc_q[0] : 32'hX, 32'h300);

        // ---- asynchronous reset in the middle of WAIT ----
        m_lat = 3;
        wait_acc("rst_acc_timeout");
        #3 rst_n = 1'b0;
        #1;
        chk_reset_outputs("async_rst");
        m_pend = 1'b0; imem_rsp_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // ---- randomized traffic against the stream model ----
        exp_pc = 32'h0; p_hold = 1'b0; p_rq = 1'b0; p_pc = '0; p_instr = '0; p_addr = '0;
        delivered = 0; rdy_pct = 75;
        for (int i = 0; i < 3000; i++) begin
            out_ready      = ($urandom_range(3) != 0);
            redirect_valid = ($urandom_range(29) == 0);
            redirect_pc    = $urandom & 32'h3FF;
            m_lat          = int'($urandom_range(1, 3));
            tick();
            if (p_hold) begin
                chk("rnd_hold_valid", 32'(s_ov), 32'h1);
                chk("rnd_hold_pc", s_pc, p_pc);
                chk("rnd_hold_instr", s_instr, p_instr);
            end
            if (s_rv) chk("rnd_addr_align", 32'(s_addr[1:0]), 32'h0);
            if (p_rq && s_rv) chk("rnd_addr_hold", s_addr, p_addr);
            if (s_ov && out_ready && !redirect_valid) begin
                chk("rnd_out_pc", s_pc, exp_pc);
                chk("rnd_out_instr", s_instr, mem[exp_pc[9:2]]);
                chk("rnd_out_opcode", 32'(s_opc), 32'(mem[exp_pc[9:2]][6:2]));
                exp_pc = exp_pc + 32'h4;
                delivered++;
            end
            if (redirect_valid) exp_pc = {redirect_pc[31:2], 2'b00};
            p_hold = s_ov && !out_ready && !redirect_valid;
            p_rq   = s_rv && !imem_req_ready && !redirect_valid;
            p_pc = s_pc; p_instr = s_instr; p_addr = s_addr;
        end
        redirect_valid = 1'b0;
        chk("rnd_progress", 32'(delivered > 200), 32'h1);

        // ---- halt with a request outstanding ----
        out_ready = 1'b1; rdy_pct = 100; m_lat = 3;
        wait_acc("halt_acc_timeout");
        halt = 1'b1;
        g = 0;
        do begin tick(); g++; end while (!s_rsp && g < 40);
        chk("halt_rsp_seen", 32'(s_rsp), 32'h1);
        chk("halt_not_yet", 32'(s_halted), 32'h0);
        tick();
        chk("halt_halted", 32'(s_halted), 32'h1);
        chk("halt_discarded", 32'(s_ov), 32'h0);
        for (int i = 0; i < 20; i++) begin
            if (i == 10) halt = 1'b0;
            tick();
            chk("halt_no_req", 32'(s_rv), 32'h0);
            chk("halt_stays", 32'(s_halted), 32'h1);
        end
        #3 rst_n = 1'b0;
        #1;
        chk_reset_outputs("halt_rst");
        @(negedge clk);
        rst_n = 1'b1;

        // ---- PC wrap: RESET_PC = 0xFFFFFFFC ----
        b_rst_n = 1'b1;
        nw = 0; g = 0; w_addr[0] = '0; w_addr[1] = '0;
        begin
            logic b_pend = 1'b0, b_acc;
            logic [31:0] b_first_pc = '0;
            logic        b_seen = 1'b0;
            while (nw < 2 && g < 40) begin
                @(negedge clk);
                b_rsp_valid = b_pend;
                b_rsp_data  = 32'h0000_0033;
                #1;
                b_acc = b_req_valid;
                if (b_acc) begin w_addr[nw] = b_addr; nw++; end
                if (b_out_valid && !b_seen) begin b_seen = 1'b1; b_first_pc = b_out_pc; end
                @(posedge clk);
                b_pend = b_acc;
                g++;
            end
            chk("wrap_req_count", 32'(nw), 32'h2);
            chk("wrap_first_addr", w_addr[0], 32'hFFFF_FFFC);
            chk("wrap_second_addr", w_addr[1], 32'h0);
            chk("wrap_first_out_pc", b_first_pc, 32'hFFFF_FFFC);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
